// File: rtl/ps2_message_composer.sv
// Line editor between key2ascii and gpio_protocol: builds a 16-char message, commits on Enter.
// Optional blinking cursor on the LCD edit line is enabled with `define CURSOR_BLINK_EN.
module ps2_message_composer #(
    parameter int NUM_CHARS = 16,
    parameter int CNT_W     = 5,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   char_valid,
    input  logic [7:0]             char_in,
    input  logic                   send_done,
    output logic [8*NUM_CHARS-1:0] edit_buffer,
    output logic [8*NUM_CHARS-1:0] message_out,
    output logic                   send_req,
    output logic [CNT_W-1:0]       char_count,
    output logic                   full,
    output logic                   busy,
    output logic                   drop_pulse
);

    typedef enum logic {
        ST_EDIT,
        ST_SEND_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(NUM_CHARS);
    localparam logic [7:0]       SPACE     = 8'h20;
    localparam logic [7:0]       BACKSPACE = 8'h08;
    localparam logic [7:0]       ENTER     = 8'h0D;
    localparam logic [8*NUM_CHARS-1:0] BLANK_LINE = {NUM_CHARS{SPACE}};

    state_t                   state_q, state_d;
    logic [8*NUM_CHARS-1:0]   line_q, line_d;
    logic [8*NUM_CHARS-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     drop_q, drop_d;
    logic                     sync1_q, sync2_q, sync_prev_q;

    logic done_rise;
    logic is_printable;

    assign done_rise    = sync2_q & ~sync_prev_q;
    assign is_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);

    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        msg_d   = msg_q;
        count_d = count_q;
        drop_d  = 1'b0;

        case (state_q)
            ST_EDIT: begin
                if (char_valid) begin
                    if (is_printable) begin
                        if (count_q != MAX_COUNT) begin
                            for (int i = 0; i < NUM_CHARS; i++) begin
                                if (CNT_W'(i) == count_q) line_d[8*i +: 8] = char_in;
                            end
                            count_d = count_q + 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (char_in == BACKSPACE) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                            for (int i = 0; i < NUM_CHARS; i++) begin
                                if (CNT_W'(i) == count_d) line_d[8*i +: 8] = SPACE;
                            end
                        end
                    end else if (char_in == ENTER) begin
                        // Empty lines are never committed.
                        if (count_q != '0) begin
                            msg_d   = line_q;
                            state_d = ST_SEND_WAIT;
                        end
                    end
                end
            end

            ST_SEND_WAIT: begin
                // Keys typed while a message is in flight, including on the done edge, are lost.
                if (char_valid) drop_d = 1'b1;
                if (done_rise) begin
                    line_d  = BLANK_LINE;
                    count_d = '0;
                    state_d = ST_EDIT;
                end
            end

            default: state_d = ST_EDIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
    // NOTE: the line and message stores are reset because the LCD shows them straight after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EDIT;
            line_q      <= BLANK_LINE;
            msg_q       <= BLANK_LINE;
            count_q     <= '0;
            drop_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            msg_q       <= msg_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            sync1_q     <= send_done;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    assign message_out = msg_q;
    assign send_req    = (state_q == ST_SEND_WAIT);
    assign busy        = (state_q == ST_SEND_WAIT);
    assign char_count  = count_q;
    assign full        = (count_q == MAX_COUNT);
    assign drop_pulse  = drop_q;

`ifdef CURSOR_BLINK_EN
    localparam int              BLINK_W    = $clog2(BLINK_DIV + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [7:0]      CURSOR     = 8'h5F;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Cursor is overlaid on the display only; the stored line never holds it.
    always_comb begin
        edit_buffer = line_q;
        if (state_q == ST_EDIT && count_q != MAX_COUNT && phase_q) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (CNT_W'(i) == count_q) edit_buffer[8*i +: 8] = CURSOR;
            end
        end
    end
`else
    assign edit_buffer = line_q;
`endif

endmodule

// File: tb/tb_ps2_message_composer.sv
// Self-checking bench for ps2_message_composer: directed plan plus random keystrokes
// checked against a queue-based model of the edit line.
module tb_ps2_message_composer;

    logic         clock;
    logic         reset;
    logic         char_valid;
    logic [7:0]   char_in;
    logic         send_done;
    logic [127:0] edit_buffer;
    logic [127:0] message_out;
    logic         send_req;
    logic [4:0]   char_count;
    logic         full;
    logic         busy;
    logic         drop_pulse;

    ps2_message_composer dut (
        .clock       (clock),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_in     (char_in),
        .send_done   (send_done),
        .edit_buffer (edit_buffer),
        .message_out (message_out),
        .send_req    (send_req),
        .char_count  (char_count),
        .full        (full),
        .busy        (busy),
        .drop_pulse  (drop_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: the line is a queue of typed characters.
    logic [7:0]   m_line[$];
    logic [127:0] m_msg  = {16{8'h20}};
    logic         m_busy = 1'b0;
    logic         m_drop = 1'b0;

    function automatic logic [127:0] line_packed();
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = (i < m_line.size()) ? m_line[i] : 8'h20;
        return r;
    endfunction

    task automatic model_reset();
        m_line.delete();
        m_msg  = {16{8'h20}};
        m_busy = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic [7:0] c, input logic rise);
        m_drop = 1'b0;
        if (m_busy) begin
            if (v) m_drop = 1'b1;
            if (rise) begin
                m_line.delete();
                m_busy = 1'b0;
            end
        end else if (v) begin
            if (c >= 8'h20 && c <= 8'h7E) begin
                if (m_line.size() < 16) m_line.push_back(c);
                else m_drop = 1'b1;
            end else if (c == 8'h08) begin
                if (m_line.size() > 0) void'(m_line.pop_back());
            end else if (c == 8'h0D) begin
                if (m_line.size() > 0) begin
                    m_msg  = line_packed();
                    m_busy = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".edit"},  edit_buffer, line_packed());
        chk({tag, ".msg"},   message_out, m_msg);
        chk({tag, ".req"},   128'(send_req), 128'(m_busy));
        chk({tag, ".busy"},  128'(busy), 128'(m_busy));
        chk({tag, ".count"}, 128'(char_count), 128'(m_line.size()));
        chk({tag, ".full"},  128'(full), 128'(m_line.size() == 16));
        chk({tag, ".drop"},  128'(drop_pulse), 128'(m_drop));
    endtask

    // Called at a negedge; applies one cycle of stimulus and checks at the next negedge.
    task automatic step(input logic v, input logic [7:0] c, input logic rise, input string tag);
        char_valid = v;
        char_in    = c;
        @(posedge clock);
        model_update(v, c, rise);
        @(negedge clock);
        char_valid = 1'b0;
        check_all(tag);
    endtask

    // Completes a transfer: done low long enough to clear the synchroniser, then a rising edge.
    task automatic handshake(input logic v, input logic [7:0] c, input string tag);
        send_done = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, {tag, ".low"});
        send_done = 1'b1;
        step(1'b0, 8'h00, 1'b0, {tag, ".sync1"});
        step(1'b0, 8'h00, 1'b0, {tag, ".sync2"});
        step(v, c, 1'b1, {tag, ".edge"});
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] others[5] = '{8'h00, 8'h7F, 8'h1B, 8'h0A, 8'hFF};
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 8'($urandom_range(32, 126));
            6, 7:             return 8'h08;
            8:                return 8'h0D;
            default:          return others[$urandom_range(0, 4)];
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        send_done  = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Typing "Hi"
        step(1'b1, 8'h48, 1'b0, "hi_h");
        step(1'b1, 8'h69, 1'b0, "hi_i");
        chk("hi_low16", 128'(edit_buffer[15:0]), 128'h6948);
        chk("hi_upper", 128'(edit_buffer[127:16]), 128'({14{8'h20}}));

        // Backspace past empty
        for (int i = 0; i < 3; i++) step(1'b1, 8'h08, 1'b0, "bksp");
        chk("bksp_empty", edit_buffer, {16{8'h20}});

        // Fill to 16, overflow with 'Q'
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h41 + i), 1'b0, "fill");
        chk("fill_byte15", 128'(edit_buffer[127:120]), 128'h50);
        step(1'b0, 8'h00, 1'b0, "fill_drop_clear");
        for (int i = 0; i < 16; i++) step(1'b1, 8'h08, 1'b0, "drain");

        // Commit "OK", drop 'Z', complete transfer
        step(1'b1, 8'h4F, 1'b0, "ok_o");
        step(1'b1, 8'h4B, 1'b0, "ok_k");
        step(1'b1, 8'h0D, 1'b0, "ok_enter");
        chk("ok_msg16", 128'(message_out[15:0]), 128'h4B4F);
        step(1'b1, 8'h5A, 1'b0, "ok_z_drop");
        handshake(1'b0, 8'h00, "ok_done");
        chk("ok_msg_held", 128'(message_out[15:0]), 128'h4B4F);

        // Empty Enter is ignored
        step(1'b1, 8'h0D, 1'b0, "empty_enter");
        chk("empty_req", 128'(send_req), 128'h0);

        // Commit with done already high: no edge, stays busy
        step(1'b1, 8'h41, 1'b0, "hold_a");
        step(1'b1, 8'h0D, 1'b0, "hold_enter");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, "hold_wait");
        // A key on the done edge is dropped
        handshake(1'b1, 8'h58, "edge_key");

        // Random keystrokes
        for (int n = 0; n < 400; n++) begin
            if (m_busy && $urandom_range(0, 3) == 0)
                handshake(1'($urandom_range(0, 1)), rand_char(), "rnd_hs");
            else
                step(1'($urandom_range(0, 4) != 0), rand_char(), 1'b0, "rnd");
        end

        // Asynchronous reset in the middle of SEND_WAIT
        if (m_busy) handshake(1'b0, 8'h00, "pre_rst");
        step(1'b1, 8'h52, 1'b0, "rst_r");
        step(1'b1, 8'h0D, 1'b0, "rst_enter");
        chk("rst_busy_before", 128'(busy), 128'h1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 8'h31, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_message_composer.md
Name: ps2_message_composer

Overview:
Line-editing stage between key2ascii and gpio_protocol. Accumulates ASCII characters from the PS2 path into a fixed 16-character message, handles backspace, and commits the message on Enter. Drives the LCD edit line and hands the committed 128-bit word to gpio_protocol through a request/done handshake. Runs on CLOCK_50. gpio_protocol's done is generated on the 1 Hz domain, so this block synchronises it.

Parameters:
NUM_CHARS, 16, message length in characters; message width = 8*NUM_CHARS.
CNT_W, 5, width of char_count; must hold 0..NUM_CHARS.
BLINK_DIV, 12500000, clock cycles per cursor toggle (used only with CURSOR_BLINK_EN).

Ports:
clock  input  1  system clock (CLOCK_50).
reset  input  1  asynchronous, active-high reset.
char_valid  input  1  one-cycle strobe; char_in is valid (scan_code_ready).
char_in  input  8  ASCII code from key2ascii.
send_done  input  1  level from gpio_protocol done; asynchronous to clock.
edit_buffer  output  8*NUM_CHARS  live edit line for the LCD; char 0 in bits [7:0].
message_out  output  8*NUM_CHARS  committed message to gpio_protocol message_in; same byte order.
send_req  output  1  high while a committed message awaits transmission (data_ready).
char_count  output  CNT_W  number of characters in the edit buffer.
full  output  1  char_count == NUM_CHARS.
busy  output  1  high in the SEND_WAIT state.
drop_pulse  output  1  one-cycle pulse when a valid character is discarded.

Behaviour:
- Reset (asynchronous, any state):
  - edit_buffer and message_out are all 0x20.
  - char_count=0, send_req=0, busy=0, drop_pulse=0, state=EDIT, synchroniser flops=0.
- Character classes on char_valid:
  - printable: 0x20..0x7E.
  - backspace: 0x08.
  - enter: 0x0D.
  - all other codes are ignored silently (no drop_pulse).
- EDIT state, on char_valid:
  - printable and count<NUM_CHARS: write byte at index char_count, char_count+1. Visible on outputs the cycle after the strobe.
  - printable and count==NUM_CHARS: buffer unchanged, drop_pulse=1 for one cycle.
  - backspace and count>0: char_count-1, byte at the new index becomes 0x20.
  - backspace and count==0: no change, no drop_pulse.
  - enter and count>0: next cycle message_out <= edit_buffer, send_req=1, busy=1, state=SEND_WAIT. edit_buffer is retained.
  - enter and count==0: ignored; no empty messages are sent.
- SEND_WAIT state:
  - Every char_valid of any class causes drop_pulse=1; buffers are unchanged.
  - send_done passes through a 2-flop synchroniser and then a rising-edge detector.
  - On the detected rising edge: send_req=0, busy=0, edit_buffer all 0x20, char_count=0, state=EDIT. Total latency is 3 clocks from the asynchronous edge.
  - message_out holds its value until the next commit.
  - If send_done is already high when SEND_WAIT is entered, no edge exists; the block waits for the next rising edge.
- A char_valid in the same cycle as the done edge is dropped (drop_pulse=1).
- full is combinational from char_count. drop_pulse is registered.
- char_count never exceeds NUM_CHARS and never wraps below 0.

Optional Feature:
Macro: CURSOR_BLINK_EN.
- Defined:
  - A free-running counter toggles a blink phase every BLINK_DIV clocks; the counter and phase reset to 0.
  - In EDIT with count<NUM_CHARS, edit_buffer shows byte 0x5F ('_') at index char_count while the phase is 1, and 0x20 otherwise.
  - The stored buffer is unaffected, and message_out never contains the cursor.
  - No cursor is shown in SEND_WAIT or when full.
- Undefined: no counter is built, and edit_buffer is the stored buffer exactly.

Test Plan:
1. Reset, then strobe 0x48, 0x69 -> edit_buffer[15:0]=0x6948, upper bytes 0x20, char_count=2, full=0.
2. Strobe 0x08 three times after "Hi" -> char_count 1 then 0 then 0; edit_buffer all 0x20; drop_pulse never high.
3. Strobe 17 printable chars 'A'..'Q' -> full=1 after the 16th; the 17th ('Q') is discarded with one drop_pulse cycle; byte 15='P'.
4. Strobe "OK" then 0x0D -> message_out[15:0]=0x4B4F, send_req=1, busy=1. Then strobe 'Z' -> drop_pulse, buffers unchanged. Then raise send_done -> 3 clocks later send_req=0, char_count=0, edit_buffer all 0x20, message_out still 0x4B4F.
5. 0x0D with empty buffer -> send_req stays 0. Then assert reset mid-SEND_WAIT -> all outputs return to reset values on the same edge, without waiting for a clock.
6. With CURSOR_BLINK_EN, BLINK_DIV=4, type 'A' -> byte 1 alternates 0x5F and 0x20 every 4 clocks; message_out after 0x0D has byte 1=0x20.
